// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector: matches the newest cfg_len
// sampled bits against a latched pattern and pulses out_stream once per hit.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               inp_stream,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out_stream,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   window_q, window_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic                 ovl_q, ovl_d;
  logic                 out_d;
  logic                 err_d;
  logic [CNT_W-1:0]     cnt_d;

  logic                 cfg_len_ok;
  logic [MAX_LEN-1:0]   len_mask;
  logic [MAX_LEN-1:0]   window_shift;
  logic [LEN_W-1:0]     fill_inc;
  logic                 hit;

  assign cfg_len_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign window_shift = {window_q[MAX_LEN-2:0], inp_stream};
  assign fill_inc     = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);

  // Only the newest len_q window bits take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign hit = (fill_inc >= len_q) &&
               (((window_shift ^ pat_q) & len_mask) == '0);

  // The FSM state register doubles as the armed flag.
  assign armed = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    pat_d    = pat_q;
    len_d    = len_q;
    fill_d   = fill_q;
    ovl_d    = ovl_q;
    out_d    = 1'b0;
    err_d    = cfg_err;
    cnt_d    = match_count;

    if (cfg_load) begin
      if (cfg_len_ok) begin
        pat_d    = cfg_pattern;
        len_d    = cfg_len;
        ovl_d    = cfg_overlap;
        err_d    = 1'b0;
        window_d = '0;
        fill_d   = '0;
        cnt_d    = '0;
        state_d  = RUN;
      end else begin
        err_d    = 1'b1;
        state_d  = IDLE;
      end
    end else if (state_q == RUN && en) begin
      window_d = window_shift;
      fill_d   = fill_inc;
      if (hit) begin
        out_d = 1'b1;
        if (!(&match_count)) begin
          cnt_d = match_count + CNT_W'(1);
        end
        // Non-overlapping: the next match must be built from fresh bits.
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      window_q    <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      ovl_q       <= 1'b0;
      out_stream  <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      ovl_q       <= ovl_d;
      out_stream  <= out_d;
      cfg_err     <= err_d;
      match_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: hand-computed pulses and counts, plus a
// CNT_W=2 instance sharing the same inputs for the saturation case.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // Valid/ready does not apply: inputs are sampled every rising edge when en=1,
  // cfg_load is a single-cycle strobe, outputs are registered.
  logic               clk;
  logic               rst;
  logic               en;
  logic               inp_stream;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out_stream, out_stream2;
  logic [7:0]         match_count;
  logic [1:0]         match_count2;
  logic               cfg_err, cfg_err2;
  logic               armed, armed2;

  int n_total = 0;
  int n_pass  = 0;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .inp_stream(inp_stream),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .out_stream(out_stream),
    .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
  );

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .inp_stream(inp_stream),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .out_stream(out_stream2),
    .match_count(match_count2), .cfg_err(cfg_err2), .armed(armed2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of stream input, then check the registered pulse.
  task automatic tick(input logic en_v, input logic bit_v, input logic exp_out, input string tag);
    @(negedge clk);
    en         = en_v;
    inp_stream = bit_v;
    @(posedge clk);
    #1;
    chk(tag, {31'd0, out_stream}, {31'd0, exp_out});
  endtask

  // Loads present en=1, inp=1 to show the load-cycle bit is discarded.
  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    en          = 1'b1;
    inp_stream  = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic feed(input logic [11:0] bits, input logic [11:0] exp_pulses,
                      input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, bits[i], exp_pulses[i], $sformatf("%s_bit%0d", tag, i));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; inp_stream = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    #22;
    rst = 1'b0;
    #1;
    chk("reset_out", {31'd0, out_stream}, 32'd0);
    chk("reset_cnt", {24'd0, match_count}, 32'd0);
    chk("reset_err", {31'd0, cfg_err}, 32'd0);
    chk("reset_armed", {31'd0, armed}, 32'd0);
    tick(1'b1, 1'b1, 1'b0, "idle_ignores");

    // Overlap: stream index i in bit i; pulses after bits 4, 7, 11
    load(8'b1001, 4'd4, 1'b1);
    chk("ovl_load_armed", {31'd0, armed}, 32'd1);
    chk("ovl_load_out", {31'd0, out_stream}, 32'd0);
    feed(12'b1001_1001_0011, 12'b1000_1001_0000, 12, "ovl");
    chk("ovl_count", {24'd0, match_count}, 32'd3);

    // Non-overlap: pulses after bits 4 and 11 only
    load(8'b1001, 4'd4, 1'b0);
    chk("novl_count_clr", {24'd0, match_count}, 32'd0);
    feed(12'b1001_1001_0011, 12'b1000_0001_0000, 12, "novl");
    chk("novl_count", {24'd0, match_count}, 32'd2);

    // Enable gating: 1,0,(gap),(gap),0,1 with inp=1 in the gaps
    load(8'b1001, 4'd4, 1'b1);
    tick(1'b1, 1'b1, 1'b0, "gate_b0");
    tick(1'b1, 1'b0, 1'b0, "gate_b1");
    tick(1'b0, 1'b1, 1'b0, "gate_gap0");
    tick(1'b0, 1'b1, 1'b0, "gate_gap1");
    tick(1'b1, 1'b0, 1'b0, "gate_b2");
    tick(1'b1, 1'b1, 1'b1, "gate_b3");
    tick(1'b0, 1'b0, 1'b0, "gate_after");
    chk("gate_count", {24'd0, match_count}, 32'd1);

    // Illegal lengths
    load(8'b1, 4'd0, 1'b1);
    chk("len0_err", {31'd0, cfg_err}, 32'd1);
    chk("len0_armed", {31'd0, armed}, 32'd0);
    tick(1'b1, 1'b1, 1'b0, "len0_quiet0");
    tick(1'b1, 1'b0, 1'b0, "len0_quiet1");
    load(8'b1, 4'd9, 1'b1);
    chk("len9_err", {31'd0, cfg_err}, 32'd1);
    chk("len9_armed", {31'd0, armed}, 32'd0);
    tick(1'b1, 1'b1, 1'b0, "len9_quiet0");
    tick(1'b1, 1'b1, 1'b0, "len9_quiet1");

    // len=1, pattern 1, input 1,1,0,1; the legal load clears cfg_err
    load(8'b1, 4'd1, 1'b0);
    chk("len1_err_clr", {31'd0, cfg_err}, 32'd0);
    chk("len1_armed", {31'd0, armed}, 32'd1);
    chk("len1_load_out", {31'd0, out_stream}, 32'd0);
    feed(12'b1011, 12'b1011, 4, "len1");
    chk("len1_count", {24'd0, match_count}, 32'd3);

    // len=MAX_LEN, all ones, 10 ones: pulses after bits 7, 8, 9
    load(8'hFF, 4'd8, 1'b1);
    feed(12'b11_1111_1111, 12'b11_1000_0000, 10, "len8");
    chk("len8_count", {24'd0, match_count}, 32'd3);

    // Saturation on the 2-bit counter instance
    load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b1, $sformatf("sat_bit%0d", i));
      chk($sformatf("sat_cnt%0d", i), {30'd0, match_count2}, (i < 3) ? i + 1 : 3);
    end

    // Async reset between edges while a pulse is high
    chk("pre_rst_out", {31'd0, out_stream}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", {31'd0, out_stream}, 32'd0);
    chk("arst_cnt", {24'd0, match_count}, 32'd0);
    chk("arst_cnt2", {30'd0, match_count2}, 32'd0);
    chk("arst_err", {31'd0, cfg_err}, 32'd0);
    chk("arst_armed", {31'd0, armed}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b0, "post_rst_idle");
    chk("post_rst_armed", {31'd0, armed}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Runtime-programmable serial sequence detector. It generalises the fixed-pattern detector to any pattern of 1..MAX_LEN bits, with selectable overlap mode, an input-enable and a saturating match counter. It sits on the serial input path and emits a one-cycle pulse per detected occurrence.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; not to be overridden)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  sample inp_stream this cycle when 1
inp_stream  in  1  serial input bit
cfg_load  in  1  one-cycle strobe; latch cfg_* and restart detection
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the oldest bit, bit [0] is the newest
cfg_len  in  LEN_W  pattern length, legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
out_stream  out  1  match pulse
match_count  out  CNT_W  number of matches since last load/reset, saturating
cfg_err  out  1  last cfg_load carried an illegal cfg_len
armed  out  1  a legal configuration is active

Behaviour:
- Reset (async): FSM=IDLE, window=0, fill=0. Latched pattern/len/overlap are cleared to 0. out_stream=0, match_count=0, cfg_err=0, armed=0.
- FSM states:
  - IDLE: unconfigured; inputs ignored, out_stream held 0.
  - RUN: detecting.
- cfg_load=1, any state:
  - If cfg_len is 0 or >MAX_LEN: cfg_err<=1, go to IDLE, armed<=0.
  - Otherwise: latch pattern/len/overlap, cfg_err<=0, window<=0, fill<=0, match_count<=0, go to RUN, armed<=1.
  - cfg_load has priority over en: the bit presented in the load cycle is discarded.
- RUN, en=1, no load:
  - window <= {window[MAX_LEN-2:0], inp_stream}.
  - fill <= min(fill+1, MAX_LEN).
  - Match condition, evaluated on the updated window/fill: (fill_next >= len) and window_next[len-1:0] == pattern[len-1:0]. Bits above len are don't-care.
  - On match: out_stream<=1 for exactly one cycle and match_count<=match_count+1, saturating at all-ones. If cfg_overlap=0, fill<=0, so the next match needs len fresh bits.
- RUN, en=0: window, fill and count hold; out_stream<=0.
- Latency: out_stream goes high in the cycle following the clock edge that sampled the final pattern bit. This is the same alignment as the fixed detector, so a bench sampling one cycle later sees the pulse.
- len=1: every sampled bit equal to pattern[0] gives a pulse; the overlap setting is irrelevant.
- Reset mid-stream: all history is lost and the block returns to IDLE. Software must reload the configuration.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Overlap mode: load pattern=4'b1001, len=4, overlap=1. Feed 1,1,0,0,1,0,0,1,1,0,0,1 with en=1 throughout. Required: pulses after bits 4, 7 and 11 (0-based); match_count=3.
- Non-overlap mode: same stream, overlap=0. Required: pulses after bits 4 and 11 only; match_count=2.
- Enable gating: stream 1,0,0,1 with en=0 inserted as two idle cycles between the 0s, inp_stream=1 during the gaps. Required: exactly one pulse, after the final 1; the gap bits are not sampled.
- Illegal configuration: cfg_len=0 and then cfg_len=MAX_LEN+1. Required: cfg_err=1 and armed=0 each time; out_stream stays 0 under any input. A subsequent legal load clears cfg_err.
- Length extremes: len=1 with pattern[0]=1 and input 1,1,0,1 gives 3 pulses. len=MAX_LEN with an all-ones pattern and 10 ones (overlap=1) gives a first pulse after bit 7 and 3 pulses total.
- Saturation and async reset:
  - Use CNT_W=2 with pattern 1, len=1, and 6 ones. Required: match_count sticks at 3.
  - Assert rst asynchronously between clock edges mid-stream. Required: all outputs go to 0 immediately and armed=0.
